// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - pong game-flow handshake bundle: control inputs, scores and ball-engine outputs
interface score_keeper_if;
  logic       start;
  logic       goal_p1;
  logic       goal_p2;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       ball_enable;
  logic       serve;
  logic       serve_dir;
  logic       game_over;

  modport master (
    output start, goal_p1, goal_p2,
    input  score_p1, score_p2, ball_enable, serve, serve_dir, game_over
  );

  modport slave (
    input  start, goal_p1, goal_p2,
    output score_p1, score_p2, ball_enable, serve, serve_dir, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong game-flow controller: scores, serve pause, game over and restart
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 1024
) (
  input logic           clk,
  input logic           reset,
  score_keeper_if.slave sk
);
  localparam int            CW         = $clog2(PAUSE_CYCLES);
  localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PAUSE, PLAY, OVER} state_t;

  state_t        state;
  logic [CW-1:0] pause_cnt;
  logic          start_q;
  logic          armed;
  logic [3:0]    p1;
  logic [3:0]    p2;
  logic          ball_en;
  logic          serve_r;
  logic          dir;
  logic          over;
  logic          start_rise;

  // armed blocks a start level that was already high when reset released
  assign start_rise = sk.start & ~start_q & armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pause_cnt <= '0;
      start_q   <= 1'b0;
      armed     <= 1'b0;
      p1        <= 4'd0;
      p2        <= 4'd0;
      ball_en   <= 1'b0;
      serve_r   <= 1'b0;
      dir       <= 1'b0;
      over      <= 1'b0;
    end else begin
      start_q <= sk.start;
      armed   <= 1'b1;
      serve_r <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start_rise) begin
            p1        <= 4'd0;
            p2        <= 4'd0;
            dir       <= 1'b0;
            over      <= 1'b0;
            pause_cnt <= PAUSE_LOAD;
            state     <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_cnt == '0) begin
            state   <= PLAY;
            ball_en <= 1'b1;
            serve_r <= 1'b1;
          end else begin
            pause_cnt <= pause_cnt - CW'(1);
          end
        end
        PLAY: begin
          if (sk.goal_p1 && sk.goal_p2) begin
            ball_en   <= 1'b0;
            pause_cnt <= PAUSE_LOAD;
            state     <= PAUSE;
          end else if (sk.goal_p1 || sk.goal_p2) begin
            ball_en <= 1'b0;
            // serve goes toward the player who conceded the point
            if (sk.goal_p1) begin
              p1  <= p1 + 4'd1;
              dir <= 1'b1;
            end else begin
              p2  <= p2 + 4'd1;
              dir <= 1'b0;
            end
            if ((sk.goal_p1 && (p1 + 4'd1 == WIN)) || (sk.goal_p2 && (p2 + 4'd1 == WIN))) begin
              over  <= 1'b1;
              state <= OVER;
            end else begin
              pause_cnt <= PAUSE_LOAD;
              state     <= PAUSE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sk.score_p1    = p1;
  assign sk.score_p2    = p2;
  assign sk.ball_enable = ball_en;
  assign sk.serve       = serve_r;
  assign sk.serve_dir   = dir;
  assign sk.game_over   = over;
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - random-stimulus scoreboard bench for score_keeper against a game-rule model
module tb_score_keeper;
  localparam int WIN_SCORE    = 9;
  localparam int PAUSE_CYCLES = 6;
  localparam int M_IDLE = 0, M_PAUSE = 1, M_PLAY = 2, M_OVER = 3;

  typedef struct {
    int         cyc;
    logic [11:0] v;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  int   wins_seen;
  int   serves_seen;
  bit   done;
  bit   mon_exit;
  ev_t  exp_q[$];

  score_keeper_if sk ();

  score_keeper #(
    .WIN_SCORE   (WIN_SCORE),
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sk   (sk.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // game-rule model: phase, remaining pause cycles, plain integer scores
  int   m_st = M_IDLE;
  int   m_left = 0;
  int   m_p1 = 0;
  int   m_p2 = 0;
  bit   m_be = 0, m_sv = 0, m_dir = 0, m_go = 0;
  bit   m_last_start = 1;
  logic [11:0] last_exp = '0;

  function automatic void model_step(input logic r, input logic s, input logic a, input logic b);
    logic rise;
    if (r) begin
      m_st = M_IDLE; m_p1 = 0; m_p2 = 0;
      m_be = 0; m_sv = 0; m_dir = 0; m_go = 0;
      m_last_start = 1;
      return;
    end
    rise = s && !m_last_start;
    m_last_start = s;
    m_sv = 0;
    case (m_st)
      M_IDLE, M_OVER: begin
        if (rise) begin
          m_p1 = 0; m_p2 = 0; m_dir = 0; m_go = 0;
          m_left = PAUSE_CYCLES;
          m_st = M_PAUSE;
        end
      end
      M_PAUSE: begin
        m_left--;
        if (m_left == 0) begin
          m_st = M_PLAY; m_be = 1; m_sv = 1;
        end
      end
      M_PLAY: begin
        if (a || b) begin
          m_be = 0;
          if (a && b) begin
            m_st = M_PAUSE; m_left = PAUSE_CYCLES;
          end else begin
            if (a) begin m_p1++; m_dir = 1; end
            else   begin m_p2++; m_dir = 0; end
            if (m_p1 == WIN_SCORE || m_p2 == WIN_SCORE) begin
              m_st = M_OVER; m_go = 1;
            end else begin
              m_st = M_PAUSE; m_left = PAUSE_CYCLES;
            end
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [11:0] model_vec();
    return {4'(m_p1), 4'(m_p2), m_be, m_sv, m_dir, m_go};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {sk.score_p1, sk.score_p2, sk.ball_enable, sk.serve, sk.serve_dir, sk.game_over};
  endfunction

  task automatic drive_cycle(input logic r, input logic s, input logic a, input logic b);
    ev_t e;
    logic [11:0] mv;
    @(negedge clk);
    reset = r;
    sk.start = s;
    sk.goal_p1 = a;
    sk.goal_p2 = b;
    model_step(r, s, a, b);
    mv = model_vec();
    if (mv != last_exp) begin
      e.cyc = cyc + 1;
      e.v   = mv;
      exp_q.push_back(e);
    end
    last_exp = mv;
  endtask

  // monitor: every change of the DUT output vector must match the next expected event
  initial begin
    logic [11:0] prev;
    logic [11:0] cur;
    ev_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      cur = dut_vec();
      if (reset) begin
        checks++;
        if (cur != '0) begin
          failures++;
          $display("FAIL reset_state cyc=%0d actual=%h required=000", cyc, cur);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event cyc=%0d due=%0d actual=%h required=%h",
                 cyc, exp_q[0].cyc, cur, exp_q[0].v);
        void'(exp_q.pop_front());
      end
      if (cur != prev) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d actual=%h required=%h", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.v != cur) begin
            failures++;
            $display("FAIL out_vector cyc=%0d actual=%h required=%h", cyc, cur, e.v);
          end
          if (cur[2]) serves_seen++;
          if (cur[0] && !prev[0]) wins_seen++;
        end
      end
      prev = cur;
    end
    mon_exit = 1;
  end

  initial begin
    int rst_hold;
    int goal_hold;
    int mode;
    logic st;
    logic ga;
    logic gb;
    reset = 1'b1;
    sk.start = 1'b1;
    sk.goal_p1 = 1'b0;
    sk.goal_p2 = 1'b0;
    checks = 0;
    failures = 0;
    wins_seen = 0;
    serves_seen = 0;
    done = 0;
    mon_exit = 0;

    // start held high through reset release must not start a game
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    rst_hold = 0;
    goal_hold = 0;
    ga = 0;
    gb = 0;
    st = 0;
    for (int i = 0; i < 6000; i++) begin
      if (rst_hold == 0 && $urandom_range(599) == 0) rst_hold = $urandom_range(3, 1);
      if ($urandom_range(19) == 0) st = ~st;
      if (goal_hold == 0) begin
        ga = 0;
        gb = 0;
        if ($urandom_range(3) == 0) begin
          mode = $urandom_range(9);
          ga = (mode <= 3) || (mode == 8);
          gb = (mode >= 4 && mode <= 8);
          goal_hold = (mode == 9) ? 1 : $urandom_range(5, 1);
        end
      end
      if (goal_hold > 0) goal_hold--;
      drive_cycle(rst_hold > 0, st, ga, gb);
      if (rst_hold > 0) rst_hold--;
    end

    @(negedge clk);
    done = 1;
    for (int i = 0; i < 10 && !mon_exit; i++) @(posedge clk);
    checks++;
    if (!mon_exit) begin
      failures++;
      $display("FAIL monitor_exit actual=0 required=1");
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (wins_seen == 0) begin
      failures++;
      $display("FAIL wins_seen actual=0 required=>0");
    end
    checks++;
    if (serves_seen == 0) begin
      failures++;
      $display("FAIL serves_seen actual=0 required=>0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
